// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit for the register-bank + ALU datapath.
// Walks each accepted instruction through DECODE, EXECUTE and WRITEBACK.
module datapath_sequencer #(
    parameter int         CNT_W   = 16,
    parameter logic [5:0] NOP_OPC = 6'h3F
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic             op,
    output logic [4:0]       addr_a,
    output logic [4:0]       addr_b,
    output logic [4:0]       addr_d,
    output logic [31:0]      immed,
    output logic             y_sel,
    output logic             write,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK
    } state_t;

    localparam logic [5:0] OPC_ADD  = 6'h00;
    localparam logic [5:0] OPC_SUB  = 6'h01;
    localparam logic [5:0] OPC_ADDI = 6'h10;
    localparam logic [5:0] OPC_SUBI = 6'h11;

    state_t      state, state_nxt;
    logic [31:0] ir;
    logic        op_q, y_sel_q;
    logic        in_op, in_y_sel;
    logic        is_alu, is_nop;
    logic [5:0]  opcode;

    assign opcode = ir[31:26];
    assign is_alu = (opcode == OPC_ADD) || (opcode == OPC_SUB) ||
                    (opcode == OPC_ADDI) || (opcode == OPC_SUBI);
    assign is_nop = !is_alu && (opcode == NOP_OPC);

    // ALU controls are decoded from the incoming word and captured with it, so
    // a cleared instruction register still presents op = y_sel = 0.
    always_comb begin
        in_op    = 1'b0;
        in_y_sel = 1'b0;
        case (instr[31:26])
            OPC_ADD:  begin in_op = 1'b0; in_y_sel = 1'b1; end
            OPC_SUB:  begin in_op = 1'b1; in_y_sel = 1'b1; end
            OPC_ADDI: begin in_op = 1'b0; in_y_sel = 1'b0; end
            OPC_SUBI: begin in_op = 1'b1; in_y_sel = 1'b0; end
            default:  ;
        endcase
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ir      <= '0;
            op_q    <= 1'b0;
            y_sel_q <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && instr_valid) begin
                ir      <= instr;
                op_q    <= in_op;
                y_sel_q <= in_y_sel;
            end
            if (state == S_WRITEBACK)
                retired <= retired + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, otherwise paths
    // that skip an assignment infer latches.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        write       = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid)
                    state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu)
                    state_nxt = S_EXECUTE;
                else if (is_nop)
                    state_nxt = S_WRITEBACK;
                else begin
                    illegal   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_EXECUTE:
                state_nxt = S_WRITEBACK;
            S_WRITEBACK: begin
                done      = 1'b1;
                write     = is_alu && (ir[25:21] != 5'd0);
                state_nxt = S_IDLE;
            end
            default:
                state_nxt = S_IDLE;
        endcase
    end

    assign op     = op_q;
    assign y_sel  = y_sel_q;
    assign addr_d = ir[25:21];
    assign addr_a = ir[20:16];
    assign addr_b = ir[15:11];
    assign immed  = {{16{ir[15]}}, ir[15:0]};

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized self-checking bench for datapath_sequencer; a second instance with
// a 2-bit counter exercises retired-count wrap.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;

    logic        instr_ready, op, y_sel, write, done, illegal;
    logic [4:0]  addr_a, addr_b, addr_d;
    logic [31:0] immed;
    logic [15:0] retired;

    logic        b_instr_ready, b_op, b_y_sel, b_write, b_done, b_illegal;
    logic [4:0]  b_addr_a, b_addr_b, b_addr_d;
    logic [31:0] b_immed;
    logic [1:0]  b_retired;

    int vectors     = 0;
    int miscompares = 0;
    int model_count = 0;
    int cyc         = 0;

    datapath_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .op(op), .addr_a(addr_a), .addr_b(addr_b),
        .addr_d(addr_d), .immed(immed), .y_sel(y_sel), .write(write),
        .done(done), .illegal(illegal), .retired(retired)
    );

    datapath_sequencer #(.CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(b_instr_ready), .op(b_op), .addr_a(b_addr_a), .addr_b(b_addr_b),
        .addr_d(b_addr_d), .immed(b_immed), .y_sel(b_y_sel), .write(b_write),
        .done(b_done), .illegal(b_illegal), .retired(b_retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Issues one instruction and checks every cycle until it is back in IDLE.
    // Expected behaviour comes from the opcode table: latency, write, fields.
    task automatic run_instr(input logic [31:0] w, input bit hold_valid, output int acc_cyc);
        int          lat;
        bit          ill, alu, wr, e_op, e_y;
        logic [31:0] e_imm;
        int          waitc;
        lat = 1; ill = 1'b1; alu = 1'b0; e_op = 1'b0; e_y = 1'b0; waitc = 0;
        case (w[31:26])
            6'h00: begin lat = 3; ill = 0; alu = 1; e_op = 0; e_y = 1; end
            6'h01: begin lat = 3; ill = 0; alu = 1; e_op = 1; e_y = 1; end
            6'h10: begin lat = 3; ill = 0; alu = 1; e_op = 0; e_y = 0; end
            6'h11: begin lat = 3; ill = 0; alu = 1; e_op = 1; e_y = 0; end
            6'h3F: begin lat = 2; ill = 0; end
            default: ;
        endcase
        wr    = alu && (w[25:21] != 5'd0);
        e_imm = $signed(w[15:0]);
        acc_cyc = -1;

        while (!instr_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout: instr_ready=%b required 1 within 20 cycles", instr_ready);
            return;
        end
        instr = w; instr_valid = 1'b1; acc_cyc = cyc;

        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                instr       = $urandom;
                instr_valid = hold_valid;
            end
            if (k <= lat) begin
                vectors += 9;
                if (instr_ready !== 1'b0) begin miscompares++; $display("FAIL busy_ready k=%0d: got %b want 0", k, instr_ready); end
                if (illegal !== (ill && k == 1)) begin miscompares++; $display("FAIL illegal k=%0d w=%h: got %b want %b", k, w, illegal, ill && k == 1); end
                if (done !== (!ill && k == lat)) begin miscompares++; $display("FAIL done k=%0d w=%h: got %b want %b", k, w, done, !ill && k == lat); end
                if (write !== (wr && k == lat)) begin miscompares++; $display("FAIL write k=%0d w=%h: got %b want %b", k, w, write, wr && k == lat); end
                if (addr_a !== w[20:16]) begin miscompares++; $display("FAIL addr_a k=%0d: got %0d want %0d", k, addr_a, w[20:16]); end
                if (addr_b !== w[15:11]) begin miscompares++; $display("FAIL addr_b k=%0d: got %0d want %0d", k, addr_b, w[15:11]); end
                if (addr_d !== w[25:21]) begin miscompares++; $display("FAIL addr_d k=%0d: got %0d want %0d", k, addr_d, w[25:21]); end
                if (immed !== e_imm) begin miscompares++; $display("FAIL immed k=%0d: got %h want %h", k, immed, e_imm); end
                if (retired !== 16'(model_count)) begin miscompares++; $display("FAIL retired_busy k=%0d: got %0d want %0d", k, retired, 16'(model_count)); end
                if (alu) begin
                    vectors += 2;
                    if (op !== e_op) begin miscompares++; $display("FAIL op k=%0d w=%h: got %b want %b", k, w, op, e_op); end
                    if (y_sel !== e_y) begin miscompares++; $display("FAIL y_sel k=%0d w=%h: got %b want %b", k, w, y_sel, e_y); end
                end
            end else begin
                if (!ill) model_count++;
                vectors += 4;
                if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready w=%h: got %b want 1", w, instr_ready); end
                if ((write | done | illegal) !== 1'b0) begin miscompares++; $display("FAIL idle_pulses: w/d/i=%b%b%b want 000", write, done, illegal); end
                if (retired !== 16'(model_count)) begin miscompares++; $display("FAIL retired: got %0d want %0d", retired, 16'(model_count)); end
                if (b_retired !== 2'(model_count)) begin miscompares++; $display("FAIL retired_w2: got %0d want %0d", b_retired, 2'(model_count)); end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; instr_valid = 1'b0; instr = $urandom;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_count = 0;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        vectors += 6;
        if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready: got %b want 1", tag, instr_ready); end
        if ({op, y_sel, write, done, illegal} !== 5'b0) begin miscompares++; $display("FAIL %s_ctrl: op/y/w/d/i=%b want 00000", tag, {op, y_sel, write, done, illegal}); end
        if ({addr_a, addr_b, addr_d} !== 15'd0) begin miscompares++; $display("FAIL %s_addr: got %h want 0", tag, {addr_a, addr_b, addr_d}); end
        if (immed !== 32'd0) begin miscompares++; $display("FAIL %s_immed: got %h want 0", tag, immed); end
        if (retired !== 16'd0) begin miscompares++; $display("FAIL %s_retired: got %0d want 0", tag, retired); end
        if (b_retired !== 2'd0) begin miscompares++; $display("FAIL %s_retired_w2: got %0d want 0", tag, b_retired); end
    endtask

    task automatic test_reset();
        apply_reset();
        check_reset_values("reset");
    endtask

    task automatic test_add();
        int a;
        run_instr(32'h0022_1800, 1'b0, a);
    endtask

    task automatic test_subi_neg();
        int a;
        run_instr(32'h4440_FFFE, 1'b0, a);
        run_instr(32'h4060_8000, 1'b0, a);
    endtask

    task automatic test_nop_rd0();
        int a;
        run_instr(32'hFC00_0000 | ($urandom & 32'h03FF_FFFF), 1'b0, a);
        run_instr(32'h0002_1800, 1'b0, a);
    endtask

    task automatic test_illegal();
        int a;
        run_instr(32'h1422_1800, 1'b0, a);
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        run_instr(32'h0022_1800, 1'b1, a0);
        run_instr(32'h4440_FFFE, 1'b1, a1);
        run_instr(32'h04A5_3000, 1'b1, a2);
        instr_valid = 1'b0;
        vectors += 2;
        if (a1 - a0 !== 4) begin miscompares++; $display("FAIL b2b_spacing1: got %0d want 4", a1 - a0); end
        if (a2 - a1 !== 4) begin miscompares++; $display("FAIL b2b_spacing2: got %0d want 4", a2 - a1); end
    endtask

    task automatic test_random();
        int          a;
        logic [31:0] w;
        logic [5:0]  opc;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: opc = 6'h00;
                1: opc = 6'h01;
                2: opc = 6'h10;
                3: opc = 6'h11;
                4: opc = 6'h3F;
                default: opc = 6'($urandom);
            endcase
            w = $urandom;
            w[31:26] = opc;
            run_instr(w, $urandom_range(0, 1) == 1, a);
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int a;
        @(negedge clk);
        instr = 32'h00A2_1800; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("reset_mid");
        reset = 1'b0;
        model_count = 0;
        @(negedge clk);
        check_reset_values("after_reset_mid");
        run_instr(32'h4440_0007, 1'b0, a);
    endtask

    task automatic test_wrap();
        int a;
        apply_reset();
        for (int i = 0; i < 5; i++)
            run_instr((i % 2 == 0) ? 32'h0022_1800 : 32'hFC00_0000, 1'b0, a);
        vectors += 2;
        if (b_retired !== 2'd1) begin miscompares++; $display("FAIL wrap_w2: got %0d want 1", b_retired); end
        if (retired !== 16'd5) begin miscompares++; $display("FAIL wrap_w16: got %0d want 5", retired); end
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        test_reset();
        test_add();
        test_subi_neg();
        test_nop_rd0();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
